// File: rtl/mem_request_arbiter.sv
// Shared memory port arbiter: instruction prefetch FIFO plus data load/store,
// with PC redirect discard and a halt drain into an absorbing idle state.
module mem_request_arbiter #(
  parameter int WORD_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int IBUF_DEPTH = 4,
  parameter int DPRIO      = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic              instr_valid,
  output logic [WORD_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              instr_pop,
  input  logic              dreq_ren,
  input  logic              dreq_wen,
  input  logic [ADDR_W-1:0] dreq_addr,
  input  logic [WORD_W-1:0] dreq_wdata,
  output logic              dresp_done,
  output logic [WORD_W-1:0] dresp_rdata,
  input  logic              halt,
  output logic              halted,
  output logic              mem_ren,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic [WORD_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  localparam int PW = $clog2(IBUF_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0]     DEPTH_C = CW'(IBUF_DEPTH);
  localparam logic [ADDR_W-1:0] STEP    = ADDR_W'(WORD_W / 8);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DATA, S_HALTED} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] maddr_q, maddr_d;
  logic              dwen_q, dwen_d;
  logic [WORD_W-1:0] dwdata_q, dwdata_d;
  logic              drop_q, drop_d;
  logic              halt_q, halt_d;
  logic              done_q, done_d;
  logic [WORD_W-1:0] rdata_q, rdata_d;
  logic [CW-1:0]     count_q, count_d;
  logic [PW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
  logic [WORD_W-1:0] ibuf_q [IBUF_DEPTH];
  logic [ADDR_W-1:0] ipc_q  [IBUF_DEPTH];

  logic push, pop, redir_eff, d_elig, f_elig;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    maddr_d    = maddr_q;
    dwen_d     = dwen_q;
    dwdata_d   = dwdata_q;
    drop_d     = drop_q;
    halt_d     = halt_q | halt;
    done_d     = 1'b0;
    rdata_d    = rdata_q;
    push       = 1'b0;

    // Once halted, redirects are dead but the FIFO can still be drained.
    redir_eff = redirect && (state_q != S_HALTED);
    pop       = instr_pop && (count_q != '0) && !redir_eff;
    d_elig    = (dreq_ren || dreq_wen) && !done_q;
    f_elig    = !halt_q && (redir_eff || (count_q < DEPTH_C));

    if (redir_eff) fetch_pc_d = redirect_addr;

    case (state_q)
      S_IDLE: begin
        if (d_elig && ((DPRIO != 0) || !f_elig)) begin
          state_d  = S_DATA;
          maddr_d  = dreq_addr;
          dwen_d   = dreq_wen;
          dwdata_d = dreq_wdata;
        end else if (f_elig) begin
          state_d = S_FETCH;
          maddr_d = redir_eff ? redirect_addr : fetch_pc_q;
        end else if (halt_q) begin
          state_d = S_HALTED;
        end
      end
      S_FETCH: begin
        if (mem_ready) begin
          if (!drop_q && !redir_eff) begin
            push       = 1'b1;
            fetch_pc_d = maddr_q + STEP;
          end
          drop_d  = 1'b0;
          state_d = S_IDLE;
        end else if (redir_eff) begin
          drop_d = 1'b1;
        end
      end
      S_DATA: begin
        if (mem_ready) begin
          if (!dwen_q) rdata_d = mem_rdata;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: ;
    endcase

    if (redir_eff) begin
      count_d = '0;
      wptr_d  = '0;
      rptr_d  = '0;
    end else begin
      count_d = count_q + CW'(push) - CW'(pop);
      wptr_d  = wptr_q + PW'(push);
      rptr_d  = rptr_q + PW'(pop);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= '0;
      maddr_q    <= '0;
      dwen_q     <= 1'b0;
      dwdata_q   <= '0;
      drop_q     <= 1'b0;
      halt_q     <= 1'b0;
      done_q     <= 1'b0;
      rdata_q    <= '0;
      count_q    <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      for (int i = 0; i < IBUF_DEPTH; i++) begin
        ibuf_q[i] <= '0;
        ipc_q[i]  <= '0;
      end
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      maddr_q    <= maddr_d;
      dwen_q     <= dwen_d;
      dwdata_q   <= dwdata_d;
      drop_q     <= drop_d;
      halt_q     <= halt_d;
      done_q     <= done_d;
      rdata_q    <= rdata_d;
      count_q    <= count_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      if (push) begin
        ibuf_q[wptr_q] <= mem_rdata;
        ipc_q[wptr_q]  <= maddr_q;
      end
    end
  end

  // Port strobes come only from state and the address/data latched at issue.
  assign mem_ren     = (state_q == S_FETCH) || ((state_q == S_DATA) && !dwen_q);
  assign mem_wen     = (state_q == S_DATA) && dwen_q;
  assign mem_addr    = ((state_q == S_FETCH) || (state_q == S_DATA)) ? maddr_q : '0;
  assign mem_wdata   = ((state_q == S_DATA) && dwen_q) ? dwdata_q : '0;
  assign instr_valid = (count_q != '0);
  assign instr       = ibuf_q[rptr_q];
  assign instr_pc    = ipc_q[rptr_q];
  assign dresp_done  = done_q;
  assign dresp_rdata = rdata_q;
  assign halted      = (state_q == S_HALTED);

endmodule

// File: tb/tb_mem_request_arbiter.sv
// Scoreboard bench: stimulus queues expected port accesses, instruction pops
// and data responses; a negedge monitor compares as the DUT presents them.
module tb_mem_request_arbiter;

  logic        CLK = 1'b0;
  logic        RST;
  logic        redirect;
  logic [31:0] redirect_addr;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_pop;
  logic        dreq_ren, dreq_wen;
  logic [31:0] dreq_addr, dreq_wdata;
  logic        dresp_done;
  logic [31:0] dresp_rdata;
  logic        halt, halted;
  logic        mem_ren, mem_wen;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ready;

  mem_request_arbiter #(.WORD_W(32), .ADDR_W(32), .IBUF_DEPTH(4), .DPRIO(1)) dut (
    .CLK(CLK), .RST(RST), .redirect(redirect), .redirect_addr(redirect_addr),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .instr_pop(instr_pop),
    .dreq_ren(dreq_ren), .dreq_wen(dreq_wen), .dreq_addr(dreq_addr), .dreq_wdata(dreq_wdata),
    .dresp_done(dresp_done), .dresp_rdata(dresp_rdata), .halt(halt), .halted(halted),
    .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 CLK = ~CLK;

  typedef struct { logic wen; logic [31:0] addr; logic [31:0] wdata; } acc_t;
  typedef struct { logic [31:0] pc; logic [31:0] data; } ins_t;
  acc_t        exp_acc[$];
  ins_t        exp_ins[$];
  logic [31:0] exp_rd[$];

  int n_chk  = 0;
  int n_fail = 0;
  int n_done = 0;
  int lat    = 1;
  int acc_cyc = 0;

  function automatic logic [31:0] mdl(input logic [31:0] a);
    return (a == 32'h2000) ? 32'hDEADBEEF : (a ^ 32'h5A5A_0000);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic exp_fetch(input logic [31:0] a);
    acc_t e;
    e.wen = 1'b0; e.addr = a; e.wdata = '0;
    exp_acc.push_back(e);
  endtask

  task automatic pop_one(input logic [31:0] pc);
    ins_t e;
    e.pc = pc; e.data = mdl(pc);
    exp_ins.push_back(e);
    instr_pop = 1'b1;
    tick();
    instr_pop = 1'b0;
  endtask

  task automatic wait_acc(input logic [31:0] a);
    int n = 0;
    while (!(mem_ren && mem_addr == a) && n < 100) begin tick(); n++; end
    if (n >= 100) begin
      n_chk++; n_fail++;
      $display("FAIL wait_acc: no access to %h within 100 cycles", a);
    end
  endtask

  task automatic wait_done();
    int n = 0;
    while (!dresp_done && n < 100) begin tick(); n++; end
    if (n >= 100) begin
      n_chk++; n_fail++;
      $display("FAIL wait_done: dresp_done=0 after 100 cycles, required 1");
    end
  endtask

  // Memory model: ready in the lat-th cycle of every access.
  always begin
    @(posedge CLK); #1;
    if ((mem_ren || mem_wen) && !RST) begin
      if (acc_cyc + 1 >= lat) begin mem_ready = 1'b1; acc_cyc = 0; end
      else begin mem_ready = 1'b0; acc_cyc++; end
      mem_rdata = mdl(mem_addr);
    end else begin
      mem_ready = 1'b0; acc_cyc = 0; mem_rdata = '0;
    end
  end

  // Monitor
  logic prev_act = 1'b0;
  acc_t ma;
  ins_t mi;
  logic [31:0] mr;
  always @(negedge CLK) begin
    if (!RST) begin
      if ((mem_ren || mem_wen) && !prev_act) begin
        if (exp_acc.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_access: addr %h wen %b, required none", mem_addr, mem_wen);
        end else begin
          ma = exp_acc.pop_front();
          chk("acc_addr", mem_addr, ma.addr);
          chk("acc_wen", {31'd0, mem_wen}, {31'd0, ma.wen});
          if (ma.wen) chk("acc_wdata", mem_wdata, ma.wdata);
        end
      end
      prev_act = mem_ren || mem_wen;
      if (instr_pop && instr_valid && !redirect) begin
        if (exp_ins.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_pop: pc %h, required none", instr_pc);
        end else begin
          mi = exp_ins.pop_front();
          chk("instr_pc", instr_pc, mi.pc);
          chk("instr", instr, mi.data);
        end
      end
      if (dresp_done) begin
        n_done++;
        if (exp_rd.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_dresp: rdata %h, required none", dresp_rdata);
        end else begin
          mr = exp_rd.pop_front();
          chk("dresp_rdata", dresp_rdata, mr);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    acc_t w;
    int popped;
    int guard;
    RST = 1'b1; redirect = 1'b0; redirect_addr = '0; instr_pop = 1'b0;
    dreq_ren = 1'b0; dreq_wen = 1'b0; dreq_addr = '0; dreq_wdata = '0; halt = 1'b0;
    mem_ready = 1'b0; mem_rdata = '0;
    repeat (3) tick();
    chk("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_dresp_done", {31'd0, dresp_done}, 32'd0);
    chk("rst_dresp_rdata", dresp_rdata, 32'd0);
    chk("rst_mem_ren", {31'd0, mem_ren}, 32'd0);
    chk("rst_mem_wen", {31'd0, mem_wen}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);

    // Redirect to 0x100 on reset release, zero-wait memory, fill FIFO.
    for (int i = 0; i < 4; i++) exp_fetch(32'h100 + 32'(4 * i));
    RST = 1'b0; redirect = 1'b1; redirect_addr = 32'h100;
    tick();
    redirect = 1'b0;
    repeat (12) tick();
    for (int i = 0; i < 3; i++) begin chk("stall_mem_ren", {31'd0, mem_ren}, 32'd0); tick(); end
    chk("full_valid", {31'd0, instr_valid}, 32'd1);
    chk("full_head_pc", instr_pc, 32'h100);
    exp_fetch(32'h110);
    pop_one(32'h100);
    repeat (6) tick();

    // Load ahead of fetch, 3-cycle memory.
    lat = 3;
    exp_fetch(32'h114);
    w.wen = 1'b0; w.addr = 32'h2000; w.wdata = '0; exp_acc.push_back(w);
    exp_fetch(32'h118);
    pop_one(32'h104);
    pop_one(32'h108);
    wait_acc(32'h114);
    dreq_ren = 1'b1; dreq_addr = 32'h2000;
    exp_rd.push_back(32'hDEADBEEF);
    wait_done();
    tick();
    dreq_ren = 1'b0;
    repeat (10) tick();
    chk("rdata_held", dresp_rdata, 32'hDEADBEEF);
    chk("done_pulses_load", n_done, 32'd1);

    // Redirect during outstanding fetch: returned word dropped.
    exp_fetch(32'h11C);
    for (int i = 0; i < 4; i++) exp_fetch(32'h400 + 32'(4 * i));
    pop_one(32'h10C);
    wait_acc(32'h11C);
    redirect = 1'b1; redirect_addr = 32'h400;
    tick();
    redirect = 1'b0;
    chk("flush_valid", {31'd0, instr_valid}, 32'd0);
    repeat (30) tick();
    chk("redir_head_pc", instr_pc, 32'h400);
    chk("redir_head", instr, mdl(32'h400));

    // Redirect, mem_ready and pop in the same cycle.
    lat = 1;
    exp_fetch(32'h410);
    for (int i = 0; i < 4; i++) exp_fetch(32'h500 + 32'(4 * i));
    pop_one(32'h400);
    wait_acc(32'h410);
    redirect = 1'b1; redirect_addr = 32'h500; instr_pop = 1'b1;
    tick();
    redirect = 1'b0;
    chk("coincide_valid", {31'd0, instr_valid}, 32'd0);
    tick();
    instr_pop = 1'b0;
    repeat (12) tick();
    chk("coincide_head_pc", instr_pc, 32'h500);

    // Streaming pops: order across pointer wrap.
    for (int i = 0; i < 10; i++) exp_fetch(32'h510 + 32'(4 * i));
    popped = 0; guard = 0;
    while (popped < 10 && guard < 200) begin
      if (instr_valid) begin
        mi.pc = 32'h500 + 32'(4 * popped); mi.data = mdl(mi.pc);
        exp_ins.push_back(mi);
        instr_pop = 1'b1; popped++;
      end else instr_pop = 1'b0;
      tick();
      guard++;
    end
    instr_pop = 1'b0;
    chk("stream_pops", popped, 32'd10);
    repeat (40) tick();

    // Halt during fetch with a pending store.
    lat = 3;
    exp_fetch(32'h538);
    w.wen = 1'b1; w.addr = 32'h3000; w.wdata = 32'h12345678; exp_acc.push_back(w);
    pop_one(32'h528);
    wait_acc(32'h538);
    halt = 1'b1; dreq_wen = 1'b1; dreq_addr = 32'h3000; dreq_wdata = 32'h12345678;
    exp_rd.push_back(32'hDEADBEEF);
    tick();
    halt = 1'b0;
    wait_done();
    tick();
    dreq_wen = 1'b0;
    guard = 0;
    while (!halted && guard < 20) begin tick(); guard++; end
    chk("halted", {31'd0, halted}, 32'd1);
    redirect = 1'b1; redirect_addr = 32'h600; dreq_ren = 1'b1; dreq_addr = 32'h2000;
    repeat (5) tick();
    chk("halt_mem_ren", {31'd0, mem_ren}, 32'd0);
    chk("halt_mem_wen", {31'd0, mem_wen}, 32'd0);
    redirect = 1'b0; dreq_ren = 1'b0;
    chk("halted_sticky", {31'd0, halted}, 32'd1);
    pop_one(32'h52C);
    pop_one(32'h530);
    pop_one(32'h534);
    pop_one(32'h538);
    chk("drained_valid", {31'd0, instr_valid}, 32'd0);

    chk("acc_queue_empty", exp_acc.size(), 32'd0);
    chk("ins_queue_empty", exp_ins.size(), 32'd0);
    chk("rd_queue_empty", exp_rd.size(), 32'd0);
    chk("done_pulses_total", n_done, 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
